priority_decoder: RTL and testbench
===================================

// Module: priority_decoder
// PURPOSE
// - Inverse end of the priority-encoder path. Accepts a one-hot left (MSB-most) / right (LSB-most)
//   vector pair and recovers from it:
//   - the binary bit indices;
//   - the inclusive span mask between the two bits;
//   - an error flag for malformed pairs.
// - Low-area multi-cycle bit-serial scan, one bit per clock.
// - Sits downstream of the encoder; ready/valid handshake on both sides.
// PARAMETERS
// - WIDTH  16               vector width, >= 2
// - IDX_W  $clog2(WIDTH)    index width (derived, do not override)
// PORTS
// - clk_i          in   1      clock, all logic on rising edge
// - rst_n_i        in   1      asynchronous active-low reset
// - data_left_i    in   WIDTH  one-hot leftmost-set-bit vector
// - data_right_i   in   WIDTH  one-hot rightmost-set-bit vector
// - data_val_i     in   1      input valid
// - data_ready_o   out  1      input ready (high only in IDLE)
// - idx_left_o     out  IDX_W  binary index of left bit
// - idx_right_o    out  IDX_W  binary index of right bit
// - span_o         out  WIDTH  ones from idx_right_o to idx_left_o inclusive
// - error_o        out  1      malformed input pair
// - data_val_o     out  1      result valid
// - data_ready_i   in   1      downstream ready
// - err_cnt_o      out  16     error counter (only with PRIORITY_DECODER_ERR_CNT_EN)
// BEHAVIOUR
// - Reset (async assert, sync-released by the system):
//   - FSM=IDLE; every output 0 except data_ready_o=1; scan counter and capture registers 0.
// - FSM states:
//   - IDLE: data_ready_o=1. On data_val_i&data_ready_o, capture both vectors, cnt=0 -> SCAN.
//   - SCAN: data_ready_o=0. Each cycle examine bit cnt of both captured vectors:
//     - left bit set: record idx_left=cnt, increment left hit count (saturating at 2);
//     - right bit set: same for idx_right and the right hit count;
//     - span[cnt] = (right seen at or before cnt) && !(left seen strictly before cnt);
//     - cnt==WIDTH-1 -> DONE, else cnt++.
//   - DONE: data_val_o=1. Outputs are registered and stable while data_ready_i=0.
//     On data_ready_i -> IDLE, data_val_o=0 next cycle.
// - Latency:
//   - acceptance in cycle T -> data_val_o high in cycle T+WIDTH+1.
//   - Throughput: one pair per WIDTH+2 cycles minimum.
// - Result classification at DONE:
//   - Empty (both vectors 0): legal. error_o=0, idx_*=0, span_o=0.
//   - Legal: exactly one bit in each vector and idx_right<=idx_left. error_o=0, span as scanned.
//   - Error (any other case): error_o=1, idx_left_o=idx_right_o=0, span_o=0. Error cases:
//     - a vector with >1 bit set;
//     - exactly one vector zero;
//     - idx_right>idx_left.
// - error_o is valid only with data_val_o; it is cleared on leaving DONE.
// - No input is accepted outside IDLE. data_val_i in SCAN/DONE is ignored, not queued.
// - Reset mid-SCAN or mid-DONE aborts the current pair; no partial result is emitted.
// CONFIGURATION
// - PRIORITY_DECODER_ERR_CNT_EN defined:
//   - err_cnt_o port present;
//   - increments by 1 on each DONE->IDLE transfer with error_o=1;
//   - saturates at 16'hFFFF; reset to 0.
// - PRIORITY_DECODER_ERR_CNT_EN undefined: err_cnt_o port and counter absent. All else identical.
// TESTING
// All tests use WIDTH=16.
// 1. left=16'h0080, right=16'h0004 -> idx_left=7, idx_right=2, span=16'h00FC, error=0,
//    data_val_o 17 cycles after accept.
// 2. left=16'h0000, right=16'h0000 -> idx_left=0, idx_right=0, span=0, error=0 (empty, legal).
// 3. left=16'h0003, right=16'h0001 -> error=1, span=0, idx=0; err_cnt_o 0->1 when EN defined.
// 4. left=16'h0010, right=16'h0100 -> error=1 (right above left).
//    left=right=16'h8000 -> idx=15/15, span=16'h8000.
// 5. Backpressure: data_ready_i=0 for 5 cycles in DONE -> outputs stable, data_ready_o=0,
//    data_val_i pulses ignored. Then data_ready_i=1 -> IDLE, next pair accepted.
// 6. rst_n_i low for 1 cycle in mid-SCAN (cnt=6) -> all outputs 0 immediately, data_ready_o=1,
//    no data_val_o for the aborted pair; a following pair completes normally.

Source files
------------

// File: rtl/priority_decoder.sv
// Bit-serial decoder for a one-hot left/right pair: recovers both indices, the inclusive span and a
// malformed-pair flag. Define PRIORITY_DECODER_ERR_CNT_EN to add the saturating err_cnt_o counter.
module priority_decoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_left_i,
  input  logic [WIDTH-1:0] data_right_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [IDX_W-1:0] idx_left_o,
  output logic [IDX_W-1:0] idx_right_o,
  output logic [WIDTH-1:0] span_o,
  output logic             error_o,
  output logic             data_val_o,
  input  logic             data_ready_i
`ifdef PRIORITY_DECODER_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt_o
`endif
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_SCAN   = 2'd1;
  localparam logic [1:0]       S_DONE   = 2'd2;
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] left_q, right_q, span_q;
  logic [IDX_W-1:0] idxl_q, idxr_q;
  logic [1:0]       lhit_q, rhit_q;
  logic             l_seen_q, r_seen_q;

  // next-step values of the scan, one bit per clock
  logic             bit_l, bit_r, span_bit, legal;
  logic [1:0]       lhit_nxt, rhit_nxt;
  logic [IDX_W-1:0] idxl_nxt, idxr_nxt;
  logic [WIDTH-1:0] span_nxt;

  assign data_ready_o = (state == S_IDLE);

  always_comb begin
    bit_l    = left_q[cnt];
    bit_r    = right_q[cnt];
    lhit_nxt = (bit_l && lhit_q != 2'd2) ? lhit_q + 2'd1 : lhit_q;
    rhit_nxt = (bit_r && rhit_q != 2'd2) ? rhit_q + 2'd1 : rhit_q;
    idxl_nxt = bit_l ? cnt : idxl_q;
    idxr_nxt = bit_r ? cnt : idxr_q;
    // the left bit itself stays inside the span; only bits above it are excluded
    span_bit = (r_seen_q | bit_r) & ~l_seen_q;
    span_nxt = span_q | (WIDTH'(span_bit) << cnt);
    legal    = (lhit_nxt == 2'd0 && rhit_nxt == 2'd0) ||
               (lhit_nxt == 2'd1 && rhit_nxt == 2'd1 && idxr_nxt <= idxl_nxt);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      left_q      <= '0;
      right_q     <= '0;
      span_q      <= '0;
      idxl_q      <= '0;
      idxr_q      <= '0;
      lhit_q      <= '0;
      rhit_q      <= '0;
      l_seen_q    <= 1'b0;
      r_seen_q    <= 1'b0;
      idx_left_o  <= '0;
      idx_right_o <= '0;
      span_o      <= '0;
      error_o     <= 1'b0;
      data_val_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_val_i) begin
            left_q   <= data_left_i;
            right_q  <= data_right_i;
            cnt      <= '0;
            span_q   <= '0;
            idxl_q   <= '0;
            idxr_q   <= '0;
            lhit_q   <= '0;
            rhit_q   <= '0;
            l_seen_q <= 1'b0;
            r_seen_q <= 1'b0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          span_q   <= span_nxt;
          idxl_q   <= idxl_nxt;
          idxr_q   <= idxr_nxt;
          lhit_q   <= lhit_nxt;
          rhit_q   <= rhit_nxt;
          l_seen_q <= l_seen_q | bit_l;
          r_seen_q <= r_seen_q | bit_r;
          if (cnt == CNT_LAST) begin
            state       <= S_DONE;
            data_val_o  <= 1'b1;
            error_o     <= ~legal;
            idx_left_o  <= legal ? idxl_nxt : '0;
            idx_right_o <= legal ? idxr_nxt : '0;
            span_o      <= legal ? span_nxt : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (data_ready_i) begin
            state       <= S_IDLE;
            data_val_o  <= 1'b0;
            error_o     <= 1'b0;
            idx_left_o  <= '0;
            idx_right_o <= '0;
            span_o      <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PRIORITY_DECODER_ERR_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      err_cnt_o <= '0;
    else if (state == S_DONE && data_ready_i && error_o && err_cnt_o != 16'hFFFF)
      err_cnt_o <= err_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_priority_decoder.sv
// Randomized scoreboard bench for priority_decoder (WIDTH=16): driver pushes expectations from an
// arithmetic reference model, a negedge monitor pops and compares whenever data_val_o is up.
module tb_priority_decoder;
  localparam int W = 16;

  logic        clk_i = 0;
  logic        rst_n_i = 0;
  logic [15:0] data_left_i = 0, data_right_i = 0;
  logic        data_val_i = 0, data_ready_i = 1;
  logic        data_ready_o, error_o, data_val_o;
  logic [3:0]  idx_left_o, idx_right_o;
  logic [15:0] span_o;
`ifdef PRIORITY_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  priority_decoder #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .data_left_i(data_left_i), .data_right_i(data_right_i), .data_val_i(data_val_i),
    .data_ready_o(data_ready_o), .idx_left_o(idx_left_o), .idx_right_o(idx_right_o),
    .span_o(span_o), .error_o(error_o), .data_val_o(data_val_o), .data_ready_i(data_ready_i)
`ifdef PRIORITY_DECODER_ERR_CNT_EN
    , .err_cnt_o(err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  il;
    logic [3:0]  ir;
    logic [15:0] span;
    logic        err;
    int          t;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0, checks = 0, cyc = 0;
  bit   prev_val = 0, have_cur = 0, bp_rand = 0;
  int   exp_cnt = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: count bits and locate them, span from plain power-of-two arithmetic.
  function automatic exp_t model(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    int nl, nr, il, ir;
    nl = $countones(l); nr = $countones(r); il = 0; ir = 0;
    for (int i = 0; i < W; i++) begin
      if (l[i]) il = i;
      if (r[i]) ir = i;
    end
    e.il = 0; e.ir = 0; e.span = 0; e.err = 0; e.t = 0;
    if (nl == 0 && nr == 0) e.err = 0;
    else if (nl == 1 && nr == 1 && ir <= il) begin
      e.il = 4'(il); e.ir = 4'(ir);
      e.span = 16'(((1 << (il + 1)) - 1) - ((1 << ir) - 1));
    end else e.err = 1;
    return e;
  endfunction

  // monitor
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      prev_val = 0; have_cur = 0; exp_cnt = 0;
    end else if (data_val_o) begin
      if (!prev_val) begin
        if (sb.size() == 0) begin
          have_cur = 0;
          chk("unexpected_val", {31'd0, data_val_o}, 32'd0);
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          chk("latency", 32'(cyc - cur.t), 32'(W + 1));
        end
      end
      if (have_cur) begin
        chk("idx_left", {28'd0, idx_left_o}, {28'd0, cur.il});
        chk("idx_right", {28'd0, idx_right_o}, {28'd0, cur.ir});
        chk("span", {16'd0, span_o}, {16'd0, cur.span});
        chk("error", {31'd0, error_o}, {31'd0, cur.err});
        chk("ready_in_done", {31'd0, data_ready_o}, 32'd0);
`ifdef PRIORITY_DECODER_ERR_CNT_EN
        chk("err_cnt", {16'd0, err_cnt_o}, 32'(exp_cnt));
        if (data_ready_i && cur.err && exp_cnt != 16'hFFFF) exp_cnt++;
`endif
      end
      prev_val = 1;
    end else prev_val = 0;
  end

  always @(posedge clk_i) begin
    #1;
    if (bp_rand) data_ready_i = 1'($urandom_range(0, 1));
  end

  // called at posedge+#1; returns at posedge+#1 right after the accepting edge
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    int n = 0;
    while (!data_ready_o && n < 200) begin @(posedge clk_i); #1; n++; end
    if (!data_ready_o) begin
      chk("ready_timeout", {31'd0, data_ready_o}, 32'd1);
      return;
    end
    data_left_i = l; data_right_i = r; data_val_i = 1;
    e = model(l, r); e.t = cyc;
    sb.push_back(e);
    @(posedge clk_i); #1;
    data_val_i = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || data_val_o) && n < 500) begin @(posedge clk_i); #1; n++; end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] one, l, r;
    int a, b;
    one = 16'h1;
    #1;
    chk("rst_ready", {31'd0, data_ready_o}, 32'd1);
    chk("rst_val", {31'd0, data_val_o}, 32'd0);
    chk("rst_err", {31'd0, error_o}, 32'd0);
    chk("rst_span", {16'd0, span_o}, 32'd0);
    chk("rst_idx", {24'd0, idx_left_o, idx_right_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1;
    @(posedge clk_i); #1;

    // directed cases
    send(16'h0080, 16'h0004); drain();
    send(16'h0000, 16'h0000); drain();
    send(16'h0003, 16'h0001); drain();
    send(16'h0010, 16'h0100); drain();
    send(16'h8000, 16'h8000); drain();
    send(16'h0001, 16'h0001); drain();
    send(16'h8000, 16'h0001); drain();
    send(16'h0000, 16'h0020); drain();

    // backpressure: hold DONE 5 cycles while junk valid pulses are offered
    data_ready_i = 0;
    send(16'h0400, 16'h0010);
    for (int n = 0; n < 40 && !data_val_o; n++) begin @(posedge clk_i); #1; end
    chk("bp_val_seen", {31'd0, data_val_o}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      data_val_i = k[0]; data_left_i = 16'hFFFF; data_right_i = 16'h0001;
      chk("bp_ready_low", {31'd0, data_ready_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    data_val_i = 0;
    data_ready_i = 1;
    @(posedge clk_i); #1;
    chk("bp_back_idle", {31'd0, data_ready_o}, 32'd1);
    send(16'h0002, 16'h0002); drain();

    // reset in mid-scan (cnt=6) aborts the pair
    send(16'h0080, 16'h0004);
    repeat (6) @(posedge clk_i);
    #1 rst_n_i = 0;
    sb.delete();
    #1;
    chk("abort_val", {31'd0, data_val_o}, 32'd0);
    chk("abort_ready", {31'd0, data_ready_o}, 32'd1);
    chk("abort_outs", {11'd0, error_o, idx_left_o, idx_right_o, 8'd0}, 32'd0);
    chk("abort_span", {16'd0, span_o}, 32'd0);
    @(posedge clk_i); #1 rst_n_i = 1;
    repeat (30) @(posedge clk_i);
    #1;
    send(16'h0100, 16'h0008); drain();

    // random pairs with random downstream backpressure
    bp_rand = 1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = $urandom_range(0, 15); b = $urandom_range(0, a); l = one << a; r = one << b; end
        1: begin l = 0; r = 0; end
        2: begin b = $urandom_range(1, 15); a = $urandom_range(0, b - 1); l = one << a; r = one << b; end
        3: begin l = 16'($urandom) | 16'h0101; r = one << $urandom_range(0, 15); end
        4: begin l = ($urandom_range(0, 1) != 0) ? (one << $urandom_range(0, 15)) : 16'h0;
                 r = (l == 0) ? (one << $urandom_range(0, 15)) : 16'h0; end
        default: begin l = 16'($urandom); r = 16'($urandom); end
      endcase
      send(l, r);
    end
    bp_rand = 0;
    data_ready_i = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
